// File: rtl/vector_packer.sv
// vector_packer: packs variable-length trace vectors into full N-lane output vectors.
//
// Each accepted input carries L valid lanes (lane 0 oldest). L comes from the per-chain 8-bit
// firmware code selected by chainId_in. Elements are appended after any buffered residual.
// A full N-lane vector is emitted whenever N elements are available. Elements beyond N are held
// in the residual buffer. They are never emitted early. eof_in flushes a partial vector, padded
// with zeros. count_out reports the number of valid lanes in each emitted vector.
//
// Ports:
//   clk, resetn              clock, asynchronous active-low reset
//   tracing                  input accept enable
//   valid_in / ready_in      input handshake
//   eof_in                   last vector of a frame, forces a flush
//   chainId_in               firmware entry select
//   configId / configData    firmware shift-in write
//   vector_in                N lanes of DATA_WIDTH bits, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   vector_out / count_out   registered packed output and its valid-lane count
//   valid_out / ready_out    output handshake
module vector_packer #(
    parameter int unsigned            N                  = 8,
    parameter int unsigned            DATA_WIDTH         = 32,
    parameter int unsigned            MAX_CHAINS         = 4,
    parameter logic [7:0]             PERSONAL_CONFIG_ID = 8'd0,
    parameter logic [MAX_CHAINS*8-1:0] INITIAL_FIRMWARE  = '0
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          tracing,
    input  logic                          valid_in,
    output logic                          ready_in,
    input  logic                          eof_in,
    input  logic [$clog2(MAX_CHAINS)-1:0] chainId_in,
    input  logic [7:0]                    configId,
    input  logic [7:0]                    configData,
    input  logic [N*DATA_WIDTH-1:0]       vector_in,
    output logic [N*DATA_WIDTH-1:0]       vector_out,
    output logic [$clog2(N+1)-1:0]        count_out,
    output logic                          valid_out,
    input  logic                          ready_out
);

    localparam int unsigned FW = $clog2(N);      // fill width, fill is 0..N-1
    localparam int unsigned CW = $clog2(N + 1);  // lane count width, 0..N
    localparam int unsigned TW = CW + 1;         // fill + L, up to 2N-1
    localparam int unsigned SW = $clog2(2 * N);  // index into the 2N-lane concat

    logic [DATA_WIDTH-1:0]   lane_in [N];
    logic [DATA_WIDTH-1:0]   res_q   [N];
    logic [DATA_WIDTH-1:0]   cat     [2*N];
    logic [7:0]              fw_q    [MAX_CHAINS];
    logic [7:0]              code;
    logic [FW-1:0]           fill_q;
    logic                    pending_q;
    logic [CW-1:0]           len;
    logic [TW-1:0]           total;
    logic [SW-1:0]           pos;
    logic                    accept;
    logic                    cfg_wr;
    logic [N*DATA_WIDTH-1:0] cat_lo;
    logic [N*DATA_WIDTH-1:0] res_pad;

    assign cfg_wr   = (configId == PERSONAL_CONFIG_ID);
    assign ready_in = (!valid_out || ready_out) && !pending_q;
    assign accept   = valid_in && tracing && ready_in;

    // Length decode: 0 means a full vector; codes above N drop the data but still honour eof.
    always_comb begin
        code = fw_q[chainId_in];
        if (code == 8'd0) begin
            len = CW'(N);
        end else if (32'(code) <= N) begin
            len = CW'(code);
        end else begin
            len = '0;
        end
        total = TW'(fill_q) + TW'(len);
    end

    // Concat = residual lanes 0..fill-1, then input lanes 0..L-1 (barrel shift by fill).
    // Lanes beyond fill+L are zero, so the residual buffer stays zero above fill.
    always_comb begin
        pos = '0;
        for (int i = 0; i < int'(N); i++) begin
            lane_in[i] = vector_in[i*DATA_WIDTH +: DATA_WIDTH];
        end
        for (int k = 0; k < int'(2 * N); k++) begin
            cat[k] = '0;
        end
        for (int k = 0; k < int'(N); k++) begin
            if (k < int'(fill_q)) begin
                cat[k] = res_q[k];
            end
        end
        for (int j = 0; j < int'(N); j++) begin
            pos = SW'(j) + SW'(fill_q);
            if (j < int'(len)) begin
                cat[pos] = lane_in[j];
            end
        end
        for (int i = 0; i < int'(N); i++) begin
            cat_lo[i*DATA_WIDTH +: DATA_WIDTH]  = cat[i];
            res_pad[i*DATA_WIDTH +: DATA_WIDTH] = (i < int'(fill_q)) ? res_q[i] : '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_out  <= 1'b0;
            vector_out <= '0;
            count_out  <= '0;
            fill_q     <= '0;
            pending_q  <= 1'b0;
            for (int i = 0; i < int'(N); i++) begin
                res_q[i] <= '0;
            end
            for (int i = 0; i < int'(MAX_CHAINS); i++) begin
                fw_q[i] <= INITIAL_FIRMWARE[i*8 +: 8];
            end
        end else begin
            // The accept below decodes with the pre-write firmware.
            if (cfg_wr) begin
                for (int i = 0; i < int'(MAX_CHAINS) - 1; i++) begin
                    fw_q[i] <= fw_q[i+1];
                end
                fw_q[MAX_CHAINS-1] <= configData;
            end

            // Output slot is free; otherwise hold everything while stalled.
            if (!valid_out || ready_out) begin
                if (pending_q) begin
                    // Deferred eof flush of the overflow residual.
                    vector_out <= res_pad;
                    count_out  <= CW'(fill_q);
                    valid_out  <= 1'b1;
                    fill_q     <= '0;
                    pending_q  <= 1'b0;
                    for (int i = 0; i < int'(N); i++) begin
                        res_q[i] <= '0;
                    end
                end else if (accept) begin
                    if (total < TW'(N)) begin
                        if (eof_in) begin
                            vector_out <= cat_lo;
                            count_out  <= CW'(total);
                            valid_out  <= (total != '0);
                            fill_q     <= '0;
                            for (int i = 0; i < int'(N); i++) begin
                                res_q[i] <= '0;
                            end
                        end else begin
                            valid_out <= 1'b0;
                            fill_q    <= FW'(total);
                            for (int i = 0; i < int'(N); i++) begin
                                res_q[i] <= cat[i];
                            end
                        end
                    end else begin
                        vector_out <= cat_lo;
                        count_out  <= CW'(N);
                        valid_out  <= 1'b1;
                        fill_q     <= FW'(total - TW'(N));
                        pending_q  <= eof_in && (total > TW'(N));
                        for (int i = 0; i < int'(N); i++) begin
                            res_q[i] <= cat[N+i];
                        end
                    end
                end else begin
                    valid_out <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_vector_packer.sv
module tb_vector_packer;

    localparam int unsigned N  = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned MC = 4;
    localparam logic [7:0]  CFG_ID = 8'h5A;
    // firmware[0]=3, [1]=5, [2]=9 (drop), [3]=0 (full)
    localparam logic [MC*8-1:0] INIT_FW = {8'd0, 8'd9, 8'd5, 8'd3};
    localparam int J = 32'h0BAD0000;  // junk in lanes beyond L

    logic            clk;
    logic            resetn;
    logic            tracing;
    logic            valid_in;
    logic            ready_in;
    logic            eof_in;
    logic [1:0]      chainId_in;
    logic [7:0]      configId;
    logic [7:0]      configData;
    logic [N*DW-1:0] vector_in;
    logic [N*DW-1:0] vector_out;
    logic [3:0]      count_out;
    logic            valid_out;
    logic            ready_out;

    int checks = 0;
    int errors = 0;

    vector_packer #(
        .N                 (N),
        .DATA_WIDTH        (DW),
        .MAX_CHAINS        (MC),
        .PERSONAL_CONFIG_ID(CFG_ID),
        .INITIAL_FIRMWARE  (INIT_FW)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .tracing   (tracing),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .eof_in    (eof_in),
        .chainId_in(chainId_in),
        .configId  (configId),
        .configData(configData),
        .vector_in (vector_in),
        .vector_out(vector_out),
        .count_out (count_out),
        .valid_out (valid_out),
        .ready_out (ready_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] pk(input int a0, input int a1, input int a2, input int a3,
                                        input int a4, input int a5, input int a6, input int a7);
        return {a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    task automatic drv(input logic v, input logic [1:0] ch, input logic e,
                       input logic [255:0] vec);
        valid_in   = v;
        chainId_in = ch;
        eof_in     = e;
        vector_in  = vec;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drv(1'b0, 2'd0, 1'b0, '0);
    endtask

    initial begin
        resetn     = 1'b0;
        tracing    = 1'b1;
        configId   = 8'd0;
        configData = 8'd0;
        ready_out  = 1'b1;
        idle();
        #12;
        check_eq("rst_valid", valid_out, 0);
        check_eq("rst_vec", vector_out, 0);
        check_eq("rst_cnt", count_out, 0);
        check_eq("rst_ready_in", ready_in, 1);
        resetn = 1'b1;

        // Three 3-lane accepts fill one vector, 9 spills into the residual
        drv(1, 0, 0, pk(1, 2, 3, J, J, J, J, J)); tick();
        check_eq("t1_no_emit", valid_out, 0);
        drv(1, 0, 0, pk(4, 5, 6, J, J, J, J, J)); tick();
        drv(1, 0, 0, pk(7, 8, 9, J, J, J, J, J)); tick();
        check_eq("t1_valid", valid_out, 1);
        check_eq("t1_vec", vector_out, pk(1, 2, 3, 4, 5, 6, 7, 8));
        check_eq("t1_cnt", count_out, 8);
        // tracing low: input ignored, residual kept
        tracing = 1'b0;
        drv(1, 0, 0, pk(70, 71, 72, J, J, J, J, J)); tick();
        check_eq("t1_trace_off", valid_out, 0);
        tracing = 1'b1;
        drv(1, 0, 1, pk(10, 11, 12, J, J, J, J, J)); tick();
        check_eq("t1_eof_vec", vector_out, pk(9, 10, 11, 12, 0, 0, 0, 0));
        check_eq("t1_eof_cnt", count_out, 4);
        idle(); tick();
        check_eq("t1_drop_valid", valid_out, 0);

        // Partial flush on eof
        drv(1, 0, 0, pk(1, 2, 3, J, J, J, J, J)); tick();
        drv(1, 0, 1, pk(4, 5, 6, J, J, J, J, J)); tick();
        check_eq("t2_vec", vector_out, pk(1, 2, 3, 4, 5, 6, 0, 0));
        check_eq("t2_cnt", count_out, 6);
        idle(); tick();

        // Overflow with eof: full vector, then deferred residual flush
        drv(1, 0, 0, pk(1, 2, 3, J, J, J, J, J)); tick();
        drv(1, 0, 0, pk(4, 5, 6, J, J, J, J, J)); tick();
        check_eq("t3_fill6", valid_out, 0);
        drv(1, 0, 1, pk(7, 8, 9, J, J, J, J, J)); tick();
        check_eq("t3_c1_vec", vector_out, pk(1, 2, 3, 4, 5, 6, 7, 8));
        check_eq("t3_c1_cnt", count_out, 8);
        check_eq("t3_c1_ready_in", ready_in, 0);
        idle(); tick();
        check_eq("t3_c2_valid", valid_out, 1);
        check_eq("t3_c2_vec", vector_out, pk(9, 0, 0, 0, 0, 0, 0, 0));
        check_eq("t3_c2_cnt", count_out, 1);
        check_eq("t3_c2_ready_in", ready_in, 1);
        tick();
        check_eq("t3_done", valid_out, 0);

        // Backpressure on full vectors
        ready_out = 1'b0;
        drv(1, 3, 0, pk(10, 11, 12, 13, 14, 15, 16, 17)); tick();
        check_eq("t4_vec_a", vector_out, pk(10, 11, 12, 13, 14, 15, 16, 17));
        check_eq("t4_cnt_a", count_out, 8);
        check_eq("t4_ready_in", ready_in, 0);
        drv(1, 3, 0, pk(20, 21, 22, 23, 24, 25, 26, 27));
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t4_hold_vec", vector_out, pk(10, 11, 12, 13, 14, 15, 16, 17));
            check_eq("t4_hold_ready", ready_in, 0);
        end
        ready_out = 1'b1;
        #1;
        check_eq("t4_release_ready", ready_in, 1);
        tick();
        check_eq("t4_vec_b", vector_out, pk(20, 21, 22, 23, 24, 25, 26, 27));
        check_eq("t4_valid_b", valid_out, 1);
        idle(); tick();
        check_eq("t4_drain", valid_out, 0);

        // Asynchronous reset with fill=5 and an output pending
        drv(1, 1, 0, pk(1, 2, 3, 4, 5, J, J, J)); tick();
        check_eq("t5_fill5", valid_out, 0);
        drv(1, 3, 0, pk(11, 12, 13, 14, 15, 16, 17, 18)); tick();
        check_eq("t5_vec", vector_out, pk(1, 2, 3, 4, 5, 11, 12, 13));
        idle();
        #2 resetn = 1'b0;
        #1;
        check_eq("t5_rst_valid", valid_out, 0);
        check_eq("t5_rst_vec", vector_out, 0);
        check_eq("t5_rst_cnt", count_out, 0);
        #1 resetn = 1'b1;
        drv(1, 0, 1, pk(21, 22, 23, J, J, J, J, J)); tick();
        check_eq("t5_lane0_vec", vector_out, pk(21, 22, 23, 0, 0, 0, 0, 0));
        check_eq("t5_lane0_cnt", count_out, 3);
        idle(); tick();

        // Config shift-in 2,8,9,0; accept during the last write uses old code 0 (L=8)
        configId = CFG_ID;
        configData = 8'd2; tick();
        configData = 8'd8; tick();
        configData = 8'd9; tick();
        configData = 8'd0;
        drv(1, 0, 0, pk(51, 52, 53, 54, 55, 56, 57, 58)); tick();
        check_eq("t6_old_fw_vec", vector_out, pk(51, 52, 53, 54, 55, 56, 57, 58));
        check_eq("t6_old_fw_cnt", count_out, 8);
        configId = 8'd0;
        drv(1, 0, 0, pk(31, 32, J, J, J, J, J, J)); tick();
        drv(1, 2, 0, pk(90, 91, 92, 93, 94, 95, 96, 97)); tick();
        check_eq("t6_drop", valid_out, 0);
        drv(1, 0, 0, pk(33, 34, J, J, J, J, J, J)); tick();
        drv(1, 0, 0, pk(35, 36, J, J, J, J, J, J)); tick();
        drv(1, 0, 0, pk(37, 38, J, J, J, J, J, J)); tick();
        check_eq("t6_vec", vector_out, pk(31, 32, 33, 34, 35, 36, 37, 38));
        check_eq("t6_cnt", count_out, 8);
        drv(1, 0, 0, pk(41, 42, J, J, J, J, J, J)); tick();
        drv(1, 2, 1, pk(99, 99, 99, 99, 99, 99, 99, 99)); tick();
        check_eq("t6_eof_l0_vec", vector_out, pk(41, 42, 0, 0, 0, 0, 0, 0));
        check_eq("t6_eof_l0_cnt", count_out, 2);
        check_eq("t6_eof_l0_valid", valid_out, 1);
        drv(1, 2, 1, pk(98, 98, 98, 98, 98, 98, 98, 98)); tick();
        check_eq("t6_eof_empty", valid_out, 0);
        idle(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vector_packer.md
Name: vector_packer

Overview:
- Parametrised successor to the fixed N/M/1 packer.
- Packs trace vectors of any per-chain length 1..N into full N-lane output vectors. Packing is exact: overflow elements spill into a residual buffer and are never emitted early.
- Adds ready/valid backpressure, an eof-driven flush of partial vectors with zero padding, and a valid-element count on the output.
- Sits between the filter/reduce stages and the trace buffer.

Parameters:
- N, 8, lanes per vector.
- DATA_WIDTH, 32, bits per lane.
- MAX_CHAINS, 4, number of firmware chains.
- PERSONAL_CONFIG_ID, 0, configId value that addresses this block.
- INITIAL_FIRMWARE, all 0, per-chain 8-bit length codes loaded at reset.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- tracing  in  1  input accept enable.
- valid_in  in  1  input vector valid.
- ready_in  out  1  block can accept an input this cycle.
- eof_in  in  1  last vector of a frame; forces flush.
- chainId_in  in  $clog2(MAX_CHAINS)  selects the firmware entry.
- configId  in  8  configuration target id.
- configData  in  8  configuration payload.
- vector_in  in  DATA_WIDTH x N  lanes; lane 0 is the oldest element.
- vector_out  out  DATA_WIDTH x N  packed output, registered.
- count_out  out  $clog2(N+1)  number of valid lanes in vector_out (1..N).
- valid_out  out  1  output valid.
- ready_out  in  1  downstream accepts vector_out.

Behaviour:
- Reset (async, resetn=0):
  - valid_out=0, vector_out=0, count_out=0.
  - fill=0, residual buffer=0, pending_flush=0.
  - firmware=INITIAL_FIRMWARE.
  - Reset mid-operation discards residual and pending data; outputs clear immediately.
- Length decode (combinational, from firmware[chainId_in]):
  - code 0 -> L=N.
  - code 1..N -> L=code.
  - code >N -> L=0; vector dropped, but eof still honoured.
- Config:
  - When configId==PERSONAL_CONFIG_ID, firmware shifts: firmware[i]<=firmware[i+1], firmware[MAX_CHAINS-1]<=configData.
  - A write takes effect for inputs in the next cycle. Buffered data is unaffected.
- Handshake:
  - ready_in = (!valid_out || ready_out) && !pending_flush.
  - Accept when valid_in && tracing && ready_in. With tracing=0, inputs are ignored and the residual is retained.
  - The output holds vector_out/count_out stable while valid_out && !ready_out.
  - valid_out falls on the cycle after acceptance (ready_out=1) when there is no new emission.
- Packing on accept, with T = fill + L (T ≤ 2N-1):
  - Concatenation order: residual lanes 0..fill-1, then vector_in lanes 0..L-1.
  - T<N, no eof: residual<=concat, fill<=T, no emission.
  - T<N with eof: emit concat padded with zeros; count_out=T; fill<=0. If T==0, nothing is emitted.
  - T==N: emit concat; count_out=N; fill<=0.
  - T>N: emit first N elements (count N); residual<=elements N..T-1 shifted to lane 0; fill<=T-N.
  - T>N with eof: additionally set pending_flush. Next output slot emits the residual zero-padded with count_out=fill, then clears fill and pending_flush. ready_in stays 0 until that emission is accepted.
- Latency: 1 cycle from accept to valid_out.
- Lane arithmetic: fill width $clog2(N); element indices are modulo-free. The concat mux is a barrel shift of vector_in by fill.
- Simultaneous events:
  - Config write and accept in the same cycle: the accept uses the old firmware.
  - eof with L=0 and fill>0: emit residual padded.
  - eof with L=0 and fill=0: no output.

Test Plan:
- N=8, firmware[0]=3; accept {1,2,3},{4,5,6},{7,8,9} -> third accept yields vector_out=[1..8], count_out=8; fill=1 holding 9.
- firmware[0]=3; {1,2,3} then {4,5,6} with eof -> vector_out=[1,2,3,4,5,6,0,0], count_out=6; fill=0.
- fill=6 holding [1..6]; accept {7,8,9} with eof -> cycle 1: [1..8] count 8, ready_in=0; cycle 2: [9,0,0,0,0,0,0,0] count 1; then ready_in=1.
- firmware[0]=0, valid_in every cycle, ready_out=0 for 3 cycles -> vector_out stable, ready_in=0, no element lost or duplicated after release.
- fill=5; drive resetn=0 asynchronously mid-cycle -> valid_out=0 immediately; next accept of {a,b,c} starts at lane 0.
- Config: configId=PERSONAL_CONFIG_ID with configData 2,8,9,0 over 4 cycles -> firmware=[2,8,9,0]; chain 2 (code 9) inputs dropped, chain 0 packs 2 lanes per accept.
